// File: rtl/preg_freelist_ctrl.sv
// Physical-register free-list controller: fills the two-in/two-out free-list FIFO after
// reset, then grants up to two rename allocations and returns up to two freed pregs per cycle.
module preg_freelist_ctrl #(
    parameter int unsigned PREG_WIDTH     = 6,
    parameter int unsigned FREE_NUM       = 32,
    parameter int unsigned FREE_NUM_WIDTH = 5,
    parameter int unsigned INIT_BASE      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_first_i,
    input  logic                      alloc_second_i,
    output logic                      alloc_ready_o,
    output logic [PREG_WIDTH-1:0]     alloc_preg_first_o,
    output logic [PREG_WIDTH-1:0]     alloc_preg_second_o,
    input  logic                      free_first_i,
    input  logic                      free_second_i,
    input  logic [PREG_WIDTH-1:0]     free_preg_first_i,
    input  logic [PREG_WIDTH-1:0]     free_preg_second_i,
    output logic                      init_done_o,
    output logic                      overflow_err_o,
    output logic                      fl_wr_first_en_o,
    output logic                      fl_wr_second_en_o,
    output logic [PREG_WIDTH-1:0]     fl_wdata_first_o,
    output logic [PREG_WIDTH-1:0]     fl_wdata_second_o,
    output logic                      fl_rd_first_en_o,
    output logic                      fl_rd_second_en_o,
    input  logic [PREG_WIDTH-1:0]     fl_rdata_first_i,
    input  logic [PREG_WIDTH-1:0]     fl_rdata_second_i,
    input  logic [FREE_NUM_WIDTH:0]   fl_num_i
);

    localparam int unsigned CMP_W      = FREE_NUM_WIDTH + 2;
    localparam int unsigned INIT_STEPS = FREE_NUM / 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state;
    logic [FREE_NUM_WIDTH-1:0] init_cnt;
    logic [CMP_W-1:0]          occ;
    logic [CMP_W-1:0]          n_req;
    logic [CMP_W-1:0]          n_free;
    logic                      overflow_c;

    always_comb begin
        occ    = CMP_W'(fl_num_i);
        n_req  = CMP_W'(alloc_first_i) + CMP_W'(alloc_second_i);
        n_free = CMP_W'(free_first_i) + CMP_W'(free_second_i);
    end

    // FSM plus sticky status; the fill counter walks pairs of initial IDs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_INIT;
            init_cnt       <= '0;
            init_done_o    <= 1'b0;
            overflow_err_o <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + FREE_NUM_WIDTH'(1);
                    if (init_cnt == FREE_NUM_WIDTH'(INIT_STEPS - 1)) begin
                        state       <= ST_RUN;
                        init_done_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (overflow_c) begin
                        overflow_err_o <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // FIFO port control; gated by rst so nothing reaches the FIFO while reset is held
    always_comb begin
        alloc_ready_o       = 1'b0;
        fl_rd_first_en_o    = 1'b0;
        fl_rd_second_en_o   = 1'b0;
        fl_wr_first_en_o    = 1'b0;
        fl_wr_second_en_o   = 1'b0;
        fl_wdata_first_o    = '0;
        fl_wdata_second_o   = '0;
        overflow_c          = 1'b0;
        alloc_preg_first_o  = fl_rdata_first_i;
        alloc_preg_second_o = alloc_first_i ? fl_rdata_second_i : fl_rdata_first_i;

        if (rst) begin
            if (state == ST_INIT) begin
                fl_wr_first_en_o  = 1'b1;
                fl_wr_second_en_o = 1'b1;
                fl_wdata_first_o  = PREG_WIDTH'(INIT_BASE) + PREG_WIDTH'({init_cnt, 1'b0});
                fl_wdata_second_o = PREG_WIDTH'(INIT_BASE) + PREG_WIDTH'({init_cnt, 1'b1});
            end else begin
                alloc_ready_o = (occ >= n_req);
                if (alloc_ready_o && (n_req != '0)) begin
                    fl_rd_first_en_o  = 1'b1;
                    fl_rd_second_en_o = (n_req == CMP_W'(2));
                end

                // Freed pregs are compacted onto push port 0 first
                overflow_c = (n_free != '0) && ((occ + n_free) > CMP_W'(FREE_NUM));
                if (!overflow_c) begin
                    if (free_first_i) begin
                        fl_wr_first_en_o  = 1'b1;
                        fl_wdata_first_o  = free_preg_first_i;
                        fl_wr_second_en_o = free_second_i;
                        fl_wdata_second_o = free_preg_second_i;
                    end else if (free_second_i) begin
                        fl_wr_first_en_o  = 1'b1;
                        fl_wdata_first_o  = free_preg_second_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// Bench for preg_freelist_ctrl: emulates the free-list FIFO as a queue and predicts every
// controller output from the allocation/free rules, under directed and random traffic.
module tb_preg_freelist_ctrl;

    localparam int unsigned PW   = 6;
    localparam int unsigned FN   = 32;
    localparam int unsigned FNW  = 5;
    localparam int unsigned BASE = 32;
    localparam int unsigned NW   = FNW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_first_i, alloc_second_i, alloc_ready_o;
    logic [PW-1:0] alloc_preg_first_o, alloc_preg_second_o;
    logic          free_first_i, free_second_i;
    logic [PW-1:0] free_preg_first_i, free_preg_second_i;
    logic          init_done_o, overflow_err_o;
    logic          fl_wr_first_en_o, fl_wr_second_en_o;
    logic [PW-1:0] fl_wdata_first_o, fl_wdata_second_o;
    logic          fl_rd_first_en_o, fl_rd_second_en_o;
    logic [PW-1:0] fl_rdata_first_i, fl_rdata_second_i;
    logic [NW-1:0] fl_num_i;

    always #5 clk = ~clk;

    preg_freelist_ctrl #(
        .PREG_WIDTH(PW), .FREE_NUM(FN), .FREE_NUM_WIDTH(FNW), .INIT_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_first_i(alloc_first_i), .alloc_second_i(alloc_second_i),
        .alloc_ready_o(alloc_ready_o),
        .alloc_preg_first_o(alloc_preg_first_o), .alloc_preg_second_o(alloc_preg_second_o),
        .free_first_i(free_first_i), .free_second_i(free_second_i),
        .free_preg_first_i(free_preg_first_i), .free_preg_second_i(free_preg_second_i),
        .init_done_o(init_done_o), .overflow_err_o(overflow_err_o),
        .fl_wr_first_en_o(fl_wr_first_en_o), .fl_wr_second_en_o(fl_wr_second_en_o),
        .fl_wdata_first_o(fl_wdata_first_o), .fl_wdata_second_o(fl_wdata_second_o),
        .fl_rd_first_en_o(fl_rd_first_en_o), .fl_rd_second_en_o(fl_rd_second_en_o),
        .fl_rdata_first_i(fl_rdata_first_i), .fl_rdata_second_i(fl_rdata_second_i),
        .fl_num_i(fl_num_i)
    );

    // Reference state: FIFO contents, fill progress, phase and sticky error
    int unsigned q[$];
    bit          m_done;
    bit          m_ovf;
    int          m_k;
    int          nchk  = 0;
    int          npass = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wr0"},   32'(fl_wr_first_en_o), 0);
        chk({tag, "_wr1"},   32'(fl_wr_second_en_o), 0);
        chk({tag, "_rd0"},   32'(fl_rd_first_en_o), 0);
        chk({tag, "_rd1"},   32'(fl_rd_second_en_o), 0);
        chk({tag, "_ready"}, 32'(alloc_ready_o), 0);
        chk({tag, "_done"},  32'(init_done_o), 0);
        chk({tag, "_ovf"},   32'(overflow_err_o), 0);
    endtask

    // Asserts reset from a posedge+1 point with busy inputs; returns at posedge+1 with rst released
    task automatic apply_reset(input int hold);
        alloc_first_i  = 1'b1;
        alloc_second_i = 1'b1;
        free_first_i   = 1'b1;
        free_second_i  = 1'b1;
        rst = 1'b0;
        q.delete();
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_k    = 0;
        #1;
        check_idle("rst_now");
        repeat (hold) @(posedge clk);
        @(negedge clk);
        check_idle("rst_held");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic do_cycle(input bit a1, input bit a2, input bit f1, input bit f2,
                            input logic [PW-1:0] p1, input logic [PW-1:0] p2);
        int          nreq;
        int          nfree;
        bit          ready;
        int unsigned pushes[$];
        alloc_first_i      = a1;
        alloc_second_i     = a2;
        free_first_i       = f1;
        free_second_i      = f2;
        free_preg_first_i  = p1;
        free_preg_second_i = p2;
        fl_num_i           = NW'(q.size());
        fl_rdata_first_i   = (q.size() > 0) ? PW'(q[0]) : '0;
        fl_rdata_second_i  = (q.size() > 1) ? PW'(q[1]) : '0;
        @(negedge clk);
        chk("init_done", 32'(init_done_o), 32'(m_done));
        chk("overflow",  32'(overflow_err_o), 32'(m_ovf));
        if (!m_done) begin
            chk("init_wr0",   32'(fl_wr_first_en_o), 1);
            chk("init_wr1",   32'(fl_wr_second_en_o), 1);
            chk("init_wd0",   32'(fl_wdata_first_o), BASE + 2 * m_k);
            chk("init_wd1",   32'(fl_wdata_second_o), BASE + 2 * m_k + 1);
            chk("init_rd0",   32'(fl_rd_first_en_o), 0);
            chk("init_rd1",   32'(fl_rd_second_en_o), 0);
            chk("init_ready", 32'(alloc_ready_o), 0);
            q.push_back(BASE + 2 * m_k);
            q.push_back(BASE + 2 * m_k + 1);
            m_k++;
            if (m_k == FN / 2) m_done = 1'b1;
        end else begin
            nreq  = int'(a1) + int'(a2);
            ready = (q.size() >= nreq);
            chk("ready", 32'(alloc_ready_o), 32'(ready));
            chk("rd0", 32'(fl_rd_first_en_o), 32'(ready && nreq > 0));
            chk("rd1", 32'(fl_rd_second_en_o), 32'(ready && nreq == 2));
            if (ready && a1) chk("preg0", 32'(alloc_preg_first_o), q[0]);
            if (ready && a2) chk("preg1", 32'(alloc_preg_second_o), a1 ? q[1] : q[0]);
            nfree = int'(f1) + int'(f2);
            if (nfree > 0 && q.size() + nfree > FN) begin
                m_ovf = 1'b1;
            end else begin
                if (f1) pushes.push_back(32'(p1));
                if (f2) pushes.push_back(32'(p2));
            end
            chk("wr0", 32'(fl_wr_first_en_o), 32'(pushes.size() >= 1));
            chk("wr1", 32'(fl_wr_second_en_o), 32'(pushes.size() == 2));
            if (pushes.size() >= 1) chk("wd0", 32'(fl_wdata_first_o), pushes[0]);
            if (pushes.size() == 2) chk("wd1", 32'(fl_wdata_second_o), pushes[1]);
            if (ready) repeat (nreq) void'(q.pop_front());
            foreach (pushes[i]) q.push_back(pushes[i]);
        end
        @(posedge clk);
        #1;
    endtask

    // Random traffic; with guard set, frees that would overflow the list are withheld
    task automatic rand_cycle(input int unsigned ap, input int unsigned fp, input bit guard);
        bit a1 = ($urandom_range(0, 99) < ap);
        bit a2 = ($urandom_range(0, 99) < ap);
        bit f1 = ($urandom_range(0, 99) < fp);
        bit f2 = ($urandom_range(0, 99) < fp);
        if (guard && (q.size() + int'(f1) + int'(f2) > FN)) begin
            f1 = 1'b0;
            f2 = 1'b0;
        end
        do_cycle(a1, a2, f1, f2, PW'($urandom), PW'($urandom));
    endtask

    initial begin
        alloc_first_i = 0; alloc_second_i = 0; free_first_i = 0; free_second_i = 0;
        free_preg_first_i = '0; free_preg_second_i = '0;
        fl_rdata_first_i = '0; fl_rdata_second_i = '0; fl_num_i = '0;
        #2;
        apply_reset(2);

        // Fill phase: 16 pushes of consecutive pairs, inputs ignored
        for (int i = 0; i < 16; i++) rand_cycle(50, 50, 1'b0);
        chk("fill_count", q.size(), FN);

        // First run cycle: both slots get 32/33; then a second-only request
        do_cycle(1, 1, 0, 0, '0, '0);
        do_cycle(0, 1, 0, 0, '0, '0);

        for (int i = 0; i < 120; i++) rand_cycle(65, 30, 1'b1);
        for (int i = 0; i < 120; i++) rand_cycle(30, 65, 1'b1);

        // One entry left: a pair request is refused until a free lands
        for (int i = 0; i < 40 && q.size() > 1; i++) do_cycle(1, 1, 0, 0, '0, '0);
        if (q.size() == 0) do_cycle(0, 0, 1, 0, 6'd7, '0);
        chk("drained", q.size(), 1);
        do_cycle(1, 1, 0, 0, '0, '0);
        do_cycle(1, 1, 1, 0, 6'd9, '0);
        do_cycle(1, 1, 0, 0, '0, '0);

        // Second-only free lands on port 0
        do_cycle(0, 0, 0, 1, 6'd3, 6'd44);

        // Fill to capacity, then a free into the full list must be dropped and flagged
        for (int i = 0; i < 40 && q.size() < FN; i++)
            do_cycle(0, 0, 1, q.size() < FN - 1, PW'($urandom), PW'($urandom));
        chk("full", q.size(), FN);
        do_cycle(0, 0, 1, 0, 6'd5, '0);
        do_cycle(0, 0, 0, 0, '0, '0);
        do_cycle(1, 0, 0, 0, '0, '0);
        apply_reset(1);

        // Reset in the middle of the fill restarts it from the first pair
        for (int i = 0; i < 6; i++) rand_cycle(50, 50, 1'b0);
        apply_reset(1);
        for (int i = 0; i < 16; i++) rand_cycle(50, 50, 1'b0);
        for (int i = 0; i < 30; i++) rand_cycle(50, 50, 1'b1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
